// File: rtl/dom_pkg.sv
// Shared definitions for the DOM GF(4) randomness generator: LFSR geometry,
// feedback taps, FSM encoding and the randomness-width rule.
package dom_pkg;

    localparam int unsigned LFSR_W = 64;
    localparam int unsigned CNT_W  = 16;

    // x^64 + x^63 + x^61 + x^60 + 1 -> state bits 63, 62, 60, 59
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Fresh-randomness bits consumed per shared GF(4) multiplication
    function automatic int unsigned randw_f(input int unsigned shares);
        return 2 * shares * (shares - 1);
    endfunction

endpackage

// File: rtl/lfsr64_adv.sv
// Purely combinational N-step advance of the 64-bit Fibonacci LFSR; the feedback
// bits form the output word, first-generated bit in the LSB.
module lfsr64_adv
    import dom_pkg::*;
#(
    parameter int unsigned N = 24
) (
    input  logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] state_next,
    output logic [N-1:0]      word
);

    logic [LFSR_W-1:0] s;
    logic              fb;

    always_comb begin
        s    = state;
        fb   = 1'b0;
        word = '0;
        for (int unsigned i = 0; i < N; i++) begin
            fb      = ^(s & LFSR_TAPS);
            word[i] = fb;
            s       = {s[LFSR_W-2:0], fb};
        end
        state_next = s;
    end

endmodule

// File: rtl/dom_rand_gen_gf4.sv
// Fresh-randomness source for a DOM-masked GF(4) multiplier: seeded LFSR with
// warm-up, valid/ready word delivery and a reseed request after a usage limit.
module dom_rand_gen_gf4
    import dom_pkg::*;
#(
    parameter int unsigned   SHARES       = 4,
    parameter int unsigned   WARMUP_CYC   = 8,
    parameter logic [15:0]   RESEED_LIMIT = 16'hFFFF,
    localparam int unsigned  RANDW        = randw_f(SHARES)
) (
    input  logic              ClkxCI,
    input  logic              RstxRI,
    input  logic [LFSR_W-1:0] SeedxDI,
    input  logic              SeedValidxSI,
    output logic [RANDW-1:0]  ZxDO,
    output logic              ZValidxSO,
    input  logic              ZReadyxSI,
    output logic              ReseedReqxSO
);

    if (RANDW == 0 || RANDW > LFSR_W) begin : g_bad_randw
        $error("dom_rand_gen_gf4: RANDW must be in 1..64");
    end

    localparam int unsigned WCNT_W = $clog2(WARMUP_CYC + 2);

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [RANDW-1:0]    z_q, z_d;
    logic                zv_q, zv_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic [LFSR_W-1:0]   adv_state;
    logic [RANDW-1:0]    adv_word;

    lfsr64_adv #(
        .N (RANDW)
    ) u_adv (
        .state      (lfsr_q),
        .state_next (adv_state),
        .word       (adv_word)
    );

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            z_q     <= '0;
            zv_q    <= 1'b0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            z_q     <= z_d;
            zv_q    <= zv_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // WARMUP discards WARMUP_CYC words, then its last cycle registers the first
    // live word, so valid rises WARMUP_CYC+1 edges after the seed edge.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        z_d     = z_q;
        zv_d    = zv_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;

        if (SeedValidxSI) begin
            state_d = ST_WARMUP;
            lfsr_d  = (SeedxDI == '0) ? LFSR_W'(1) : SeedxDI;
            zv_d    = 1'b0;
            cnt_d   = '0;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    zv_d = 1'b0;
                end
                ST_WARMUP: begin
                    lfsr_d = adv_state;
                    if (wcnt_q == WCNT_W'(WARMUP_CYC)) begin
                        z_d     = adv_word;
                        zv_d    = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
                ST_RUN: begin
                    zv_d = 1'b1;
                    if (ZReadyxSI) begin
                        lfsr_d = adv_state;
                        z_d    = adv_word;
                        if (cnt_q != RESEED_LIMIT) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    zv_d    = 1'b0;
                end
            endcase
        end

        req_d = (cnt_d == RESEED_LIMIT);
    end

    assign ZxDO         = z_q;
    assign ZValidxSO    = zv_q;
    assign ReseedReqxSO = req_q;

endmodule

// File: doc/dom_rand_gen_gf4.md
DOM_RAND_GEN_GF4 -- requirements
Module: dom_rand_gen_gf4

Interface
REQ-001 SHALL have parameter SHARES, default 4, number of masking shares of the consuming shared GF(4) multiplier.
REQ-002 SHALL have parameter WARMUP_CYC, default 8, LFSR advance cycles after seeding before first output.
REQ-003 SHALL have parameter RESEED_LIMIT, default 16'hFFFF, words issued before a reseed request.
REQ-004 SHALL derive RANDW = 2*SHARES*(SHARES-1), which is 24 for the default; elaboration fails if RANDW > 64.
REQ-005 ClkxCI  input  1  sole clock, rising edge.
REQ-006 RstxRI  input  1  reset, asynchronous, active-high.
REQ-007 SeedxDI  input  64  LFSR seed value.
REQ-008 SeedValidxSI  input  1  seed strobe, sampled on the clock edge.
REQ-009 ZxDO  output  RANDW  fresh-randomness word, bit layout identical to the multiplier Z input.
REQ-010 ZValidxSO  output  1  ZxDO holds a valid, unconsumed word.
REQ-011 ZReadyxSI  input  1  consumer accepts ZxDO this cycle.
REQ-012 ReseedReqxSO  output  1  issued-word count reached RESEED_LIMIT.

Function
REQ-013 SHALL implement a 64-bit Fibonacci LFSR, polynomial x^64+x^63+x^61+x^60+1, shifting left with feedback into bit 0.
REQ-014 Each "advance" SHALL apply RANDW single-bit shifts combinationally in one cycle; the RANDW feedback bits, first-generated bit in LSB, form the new word.
REQ-015 SHALL use FSM states IDLE, WARMUP, RUN.
REQ-016 IDLE: ZValidxSO=0, LFSR frozen; SeedValidxSI=1 loads the seed and moves to WARMUP.
REQ-017 Seed load: SeedxDI==0 SHALL load 64'h1 instead, to avoid LFSR lockup.
REQ-018 WARMUP: advance every cycle for exactly WARMUP_CYC cycles, discarding the words.
REQ-019 On the final WARMUP cycle, the advanced word SHALL be registered into ZxDO and the FSM SHALL enter RUN.
REQ-020 ZValidxSO SHALL first rise exactly WARMUP_CYC+1 edges after the edge that sampled SeedValidxSI.
REQ-021 RUN: ZValidxSO=1 at all times.
REQ-022 RUN, ZReadyxSI=1: ZxDO SHALL be replaced by the next advanced word on the same edge, so back-to-back full throughput is one word per cycle.
REQ-023 RUN, ZReadyxSI=0: ZxDO and LFSR SHALL hold unchanged, and no word is ever repeated or skipped.
REQ-024 SeedValidxSI=1 in any state, including RUN or WARMUP, SHALL reload the seed and restart WARMUP.
REQ-025 On reseed, ZValidxSO SHALL drop on that edge, and a simultaneous ZReadyxSI handshake on that edge counts as consumed.
REQ-026 A 16-bit issued-word counter SHALL increment on each RUN handshake and saturate at RESEED_LIMIT.
REQ-027 ReseedReqxSO SHALL be registered and high while counter==RESEED_LIMIT.
REQ-028 Output SHALL continue after ReseedReqxSO rises.
REQ-029 The counter SHALL clear on seed load.
REQ-030 ZReadyxSI SHALL be ignored outside RUN.

Reset
REQ-031 RstxRI high SHALL asynchronously force state IDLE, LFSR=0, ZxDO=0, ZValidxSO=0, counter=0, ReseedReqxSO=0.
REQ-032 Reset asserted mid-RUN SHALL drop ZValidxSO immediately (not clock-aligned).
REQ-033 After reset deassertion the block SHALL stay in IDLE until the next SeedValidxSI.

Structure
REQ-034 Shared package dom_pkg SHALL hold: LFSR width 64, tap positions, FSM state encoding, RANDW computation function.
REQ-035 Sub-module lfsr64_adv SHALL be the purely combinational N-step advance (parameter N=RANDW; outputs next state and word).
REQ-036 All state SHALL be in the single ClkxCI domain; there SHALL be no combinational path from ZReadyxSI to ZxDO.

Verification
REQ-037 Reset with no seed for 20 cycles, ZReadyxSI=1 -> ZValidxSO=0 and ZxDO=0 throughout.
REQ-038 Seed 64'h0123456789ABCDEF, WARMUP_CYC=8 -> ZValidxSO rises on edge 9 after the seed edge; 100 consecutive words match the bit-serial software LFSR model.
REQ-039 Seed 64'h0 -> output stream identical to the stream for seed 64'h1.
REQ-040 RUN, ZReadyxSI toggled on a random pattern -> ZxDO stable while not ready; accepted-word sequence identical to the always-ready run.
REQ-041 RESEED_LIMIT=16'd10, always ready -> ReseedReqxSO rises after the 10th handshake and stays high; reseed clears it and ZValidxSO drops for WARMUP_CYC+1 edges.
REQ-042 RstxRI pulsed mid-RUN, between clock edges -> ZValidxSO falls asynchronously and all outputs are 0.
